// File: rtl/clac_pkg.sv
// Shared constants and encodings for the calculator sequencing engine.
package clac_pkg;

    localparam int OP_W  = 16;
    localparam int ITER  = 16;
    localparam int RES_W = 2 * OP_W;
    localparam int CNT_W = $clog2(ITER);

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_SUB = 2'b01,
        MODE_MUL = 2'b10,
        MODE_DIV = 2'b11
    } clac_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } clac_state_e;

endpackage

// File: rtl/clac_seq_ctrl_if.sv
// Register-side bundle between the AHB calculator slave (master) and the sequencer (slave).
interface clac_seq_ctrl_if;
    import clac_pkg::*;

    logic             ctrl;
    logic [1:0]       clac_mode;
    logic [OP_W-1:0]  opcode_a;
    logic [OP_W-1:0]  opcode_b;
    logic [RES_W-1:0] result;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output ctrl, clac_mode, opcode_a, opcode_b,
        input  result, busy, done, err
    );

    modport slave (
        input  ctrl, clac_mode, opcode_a, opcode_b,
        output result, busy, done, err
    );

endinterface

// File: rtl/clac_iter_unit.sv
// Iterative MUL/DIV engine, one bit per step. The divider exists only when CLAC_DIV_EN is defined.
module clac_iter_unit
    import clac_pkg::*;
(
    input  logic             hclk,
    input  logic             hresetn,
    input  logic             load,
    input  logic             step,
    input  clac_mode_e       mode,
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    output logic [RES_W-1:0] acc
`ifdef CLAC_DIV_EN
    ,
    output logic [OP_W-1:0]  quotient,
    output logic [OP_W-1:0]  remainder
`endif
);

    logic [RES_W-1:0] acc_q;
    logic [RES_W-1:0] mcand_q;
    logic [OP_W-1:0]  mplier_q;

    // Outputs include the current step so the final step's value can be captured on the same edge.
    always_comb begin
        acc = mplier_q[0] ? acc_q + mcand_q : acc_q;
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (load) begin
            acc_q    <= '0;
            mcand_q  <= RES_W'(a);
            mplier_q <= b;
        end else if (step && mode == MODE_MUL) begin
            acc_q    <= acc;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

`ifdef CLAC_DIV_EN
    logic [OP_W-1:0] dvsr_q;
    logic [OP_W-1:0] quo_q;
    logic [OP_W-1:0] rem_q;
    logic [OP_W:0]   trial;
    logic [OP_W-1:0] diff;
    logic            fits;

    // Restoring step: the dividend shifts out of quo_q MSB-first while quotient bits shift in.
    always_comb begin
        trial     = {rem_q, quo_q[OP_W-1]};
        fits      = trial >= {1'b0, dvsr_q};
        diff      = trial[OP_W-1:0] - dvsr_q;
        remainder = fits ? diff : trial[OP_W-1:0];
        quotient  = {quo_q[OP_W-2:0], fits};
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dvsr_q <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
        end else if (load) begin
            dvsr_q <= b;
            quo_q  <= a;
            rem_q  <= '0;
        end else if (step && mode == MODE_DIV) begin
            quo_q  <= quotient;
            rem_q  <= remainder;
        end
    end
`endif

endmodule

// File: rtl/clac_seq_ctrl.sv
// Calculator sequencer: start detect, IDLE/EXEC/DONE FSM, result/err registers.
// Iterative division is built only when CLAC_DIV_EN is defined; otherwise DIV reports err.
module clac_seq_ctrl
    import clac_pkg::*;
(
    input  logic hclk,
    input  logic hresetn,
    clac_seq_ctrl_if.slave bus
);

    clac_state_e      state;
    clac_mode_e       mode_q;
    logic             ctrl_d;
    logic [CNT_W-1:0] count;
    logic [OP_W-1:0]  a_q;
    logic [OP_W-1:0]  b_q;
    logic [RES_W-1:0] result_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic             start;
    logic             single_cycle;
    logic             finish;
    logic [OP_W:0]    sum;
    logic [OP_W:0]    dif;
    logic [RES_W-1:0] res_nxt;
    logic             err_nxt;
    logic [RES_W-1:0] acc;
`ifdef CLAC_DIV_EN
    logic [OP_W-1:0]  quotient;
    logic [OP_W-1:0]  remainder;
`endif

    assign start = bus.ctrl & ~ctrl_d & (state == ST_IDLE);

    clac_iter_unit u_iter (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .load      (start),
        .step      (state == ST_EXEC),
        .mode      (mode_q),
        .a         (bus.opcode_a),
        .b         (bus.opcode_b),
        .acc       (acc)
`ifdef CLAC_DIV_EN
        ,
        .quotient  (quotient),
        .remainder (remainder)
`endif
    );

    // Only MUL and a real (non-zero divisor) DIV need the full iteration count.
    always_comb begin
        single_cycle = 1'b1;
        case (mode_q)
            MODE_MUL: single_cycle = 1'b0;
`ifdef CLAC_DIV_EN
            MODE_DIV: single_cycle = (b_q == '0);
`endif
            default:  single_cycle = 1'b1;
        endcase
        finish = single_cycle | (count == CNT_W'(ITER - 1));
    end

    always_comb begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        dif     = {1'b0, a_q} - {1'b0, b_q};
        res_nxt = '0;
        err_nxt = 1'b0;
        case (mode_q)
            MODE_ADD: res_nxt = RES_W'(sum);
            MODE_SUB: res_nxt = {{(RES_W - OP_W - 1){dif[OP_W]}}, dif};
            MODE_MUL: res_nxt = acc;
            MODE_DIV: begin
`ifdef CLAC_DIV_EN
                if (b_q == '0) begin
                    res_nxt = '1;
                    err_nxt = 1'b1;
                end else begin
                    res_nxt = {remainder, quotient};
                end
`else
                res_nxt = '0;
                err_nxt = 1'b1;
`endif
            end
            default:  res_nxt = '0;
        endcase
    end

    // Control FSM; busy/done are registered alongside the state so they never glitch.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state    <= ST_IDLE;
            ctrl_d   <= 1'b0;
            count    <= '0;
            mode_q   <= MODE_ADD;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            ctrl_d <= bus.ctrl;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_EXEC;
                        count  <= '0;
                        busy_q <= 1'b1;
                        mode_q <= clac_mode_e'(bus.clac_mode);
                        a_q    <= bus.opcode_a;
                        b_q    <= bus.opcode_b;
                    end
                end
                ST_EXEC: begin
                    if (finish) begin
                        state    <= ST_DONE;
                        done_q   <= 1'b1;
                        result_q <= res_nxt;
                        err_q    <= err_nxt;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;

endmodule

// File: doc/clac_seq_ctrl.md
Name: clac_seq_ctrl

Overview:
- Sequencing engine for the calculator datapath.
- Consumes the enable, mode and operand registers driven by the AHB calculator slave: ctrl, clac_mode, opcode_a, opcode_b.
- Runs one operation per rising edge of ctrl: single-cycle add/sub, or 16-cycle iterative multiply/divide.
- Returns the 32-bit result to the slave's read-only RESULT register and exposes busy/done/err status.

Parameters:
- OP_W, 16, operand width. Result width is 2*OP_W.
- ITER, 16, iteration count for MUL/DIV. Must equal OP_W.

Ports:
- hclk  in  1  clock
- hresetn  in  1  asynchronous reset, active-low
- ctrl  in  1  enable from the slave; a rising edge starts an operation
- clac_mode  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV
- opcode_a  in  16  operand A, unsigned
- opcode_b  in  16  operand B, unsigned
- result  out  32  registered result; feeds the slave's result input
- busy  out  1  high while state != IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  error flag for the last completed operation

Behaviour:
- Reset: hresetn asynchronous, active-low; clock hclk. All outputs, state and internal registers are cleared: result=0, busy=0, done=0, err=0, state=IDLE, ctrl_d=0, count=0.
- Start detection:
  - ctrl_d is ctrl registered every cycle.
  - start = ctrl & ~ctrl_d & (state==IDLE).
  - A rising edge of ctrl while busy is ignored and is not queued.
  - ctrl falling mid-operation has no effect; the operation completes.
- Capture: on the start edge, clac_mode, opcode_a and opcode_b are latched. Later input changes do not affect the running operation.
- FSM states: IDLE -> EXEC -> DONE -> IDLE.
  - IDLE -> EXEC on start; count is cleared.
  - EXEC, ADD/SUB: one cycle, then DONE.
  - EXEC, MUL/DIV: ITER cycles. count increments 0..15; at count==15 the FSM goes to DONE.
  - EXEC, DIV with b==0: one cycle, then DONE.
  - DONE -> IDLE unconditionally after one cycle. done=1 only in DONE.
- Latency from the start edge to done high:
  - ADD/SUB: 1 cycle.
  - MUL/DIV: 16 cycles.
  - busy lasts 2 cycles for ADD/SUB and 17 cycles for MUL/DIV.
- Arithmetic:
  - ADD: result = zero-extended 17-bit sum.
  - SUB: result = (a-b) as a 17-bit signed value, sign-extended to 32 bits.
  - MUL: unsigned shift-add. Each EXEC cycle, if b[count] is set, acc += a<<count. result = acc (32-bit, cannot overflow).
  - DIV: unsigned restoring division, one quotient bit per cycle, MSB first. result = {remainder[15:0], quotient[15:0]}.
  - DIV with b==0: result = 32'hFFFF_FFFF, err=1.
- result update: written only on the EXEC->DONE transition. It holds its value through IDLE and the next EXEC; it is not cleared at start.
- err update: written at the same time as result. Set only by divide-by-zero (or by a disabled DIV, see Optional Feature); any other completion clears it.
- Reset mid-operation: the operation aborts and all state returns to reset values. No done pulse is produced.

Optional Feature:
- Macro: CLAC_DIV_EN.
- Defined: mode 11 performs the iterative restoring division described above.
- Undefined:
  - No divider logic is instantiated.
  - Mode 11 takes one EXEC cycle and completes with result=0, err=1.
  - MUL is unaffected.

Decomposition:
- Package clac_pkg holds:
  - Mode encodings MODE_ADD/MODE_SUB/MODE_MUL/MODE_DIV.
  - State encodings ST_IDLE/ST_EXEC/ST_DONE.
  - Constants OP_W=16 and ITER=16.
- Sub-module clac_iter_unit: the MUL/DIV iterative engine.
  - Inputs: load, step, mode, a, b.
  - Outputs: acc, quotient, remainder.
  - The top level keeps the FSM, start detect, count, and the result/err registers.

Test Plan:
1. ADD, a=16'hFFFF, b=16'h0001, pulse ctrl -> result=32'h0001_0000, err=0. done is high 1 cycle after the start edge; busy is high 2 cycles.
2. SUB, a=3, b=5 -> result=32'hFFFF_FFFE, err=0.
3. MUL, a=16'hFFFF, b=16'hFFFF -> result=32'hFFFE_0001. done is high exactly 16 cycles after start; busy is high 17 cycles.
4. DIV, a=100, b=7 -> result=32'h0002_000E, err=0. Then DIV with a=5, b=0 -> result=32'hFFFF_FFFF, err=1, done after 1 cycle.
5. Start MUL 3x4, toggle ctrl low/high at cycle 5 -> exactly one done pulse, result=32'h0000_000C. Start another MUL and assert hresetn low at cycle 8 -> result=0, busy=0, no done pulse.
6. Build without CLAC_DIV_EN, DIV with a=100, b=7 -> result=0, err=1, done 1 cycle after start. A following ADD 1+1 -> result=2, err=0.
